text_console_ctrl: RTL and testbench
====================================

# text_console_ctrl

Character-cell console controller that owns the write port of the 106x60 character buffer scanned by the VGA display path. Accepts a byte stream over a valid/ready handshake, tracks a cursor, and turns each byte into buffer writes: glyph stores, cursor moves, and blank-fill sweeps. Sits between any byte producer (UART receiver, test pattern source) and the character buffer; the display scan-out reads the buffer independently.

## Interface
- COLS, 106, cells per row (640/6)
- ROWS, 60, rows per screen (480/8)
- ADDR_W, 13, buffer address width; must satisfy COLS*ROWS <= 2**ADDR_W
- clk_25  in  1  pixel-domain clock, 25 MHz
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  producer has a byte
- in_data  in  8  byte: character code or control code
- in_ready  out  1  controller accepts in_data this cycle
- buf_we  out  1  character-buffer write strobe
- buf_addr  out  ADDR_W  cell index = row*COLS + col
- buf_data  out  8  character code written
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  6  current row, 0..ROWS-1
- busy  out  1  sweep in progress; equals !in_ready

## Operation
- States: IDLE, LINECLR, SCRCLR (SCRCLR exists only with the macro).
- in_ready = (state == IDLE). Accept occurs on a rising edge with in_valid && in_ready.
- Printable byte (any code except 0x0A, 0x0D, 0x08, and 0x0C when the macro is enabled): write in_data at the cursor, then advance col. At col == COLS-1, set col to 0 and perform a row advance.
- 0x0A LF: set col to 0 and perform a row advance. No glyph write.
- 0x0D CR: set col to 0. No write.
- 0x08 BS: decrement col if col > 0, else no change. No write; the cell is not erased.
- Row advance: increment row, wrapping ROWS-1 to 0. Enter LINECLR, which writes 0x20 to every cell of the new row, col 0..COLS-1 ascending, then returns to IDLE. No scrolling.
- 0x0C FF (macro only): enter SCRCLR, which writes 0x20 to cells 0..COLS*ROWS-1 ascending. Then set cursor to (0,0) and return to IDLE.
- Address arithmetic: row*COLS + col, computed at ADDR_W bits, with no truncation for legal cursor values.
- Cursor outputs always show the post-update cursor. During LINECLR they already show the new row with col 0.
- Reset values: buf_we 0, buf_addr 0, buf_data 0x20, cursor (0,0).
- State after reset:
  - With the macro: SCRCLR (in_ready 0, busy 1).
  - Without the macro: IDLE (in_ready 1, busy 0).
- Reset asserted mid-sweep aborts the sweep immediately; the partial clear is not resumed except through the macro's power-on sweep.

## Timing
- All outputs are registered.
- A glyph write appears exactly one cycle after the accept edge: buf_we high for one cycle, with buf_addr and buf_data valid in that cycle.
- Back-to-back printable bytes sustain one accept per cycle.
- A byte that triggers a row advance:
  - The accept cycle's glyph write (if any) appears the next cycle, followed immediately by COLS consecutive clear writes.
  - in_ready falls the cycle after the accept and stays low for COLS+1 cycles in total, then returns to 1.
- SCRCLR: COLS*ROWS consecutive buf_we cycles (6360 with defaults). in_ready returns the cycle after the last write.
- buf_we is never asserted in IDLE without a preceding accept.
- in_data is ignored whenever in_ready is 0.

## Configuration
- TEXT_CONSOLE_CLEAR_EN defined:
  - SCRCLR state is present.
  - Power-on/reset sweep blanks the whole buffer.
  - 0x0C triggers a full clear.
- Undefined:
  - No SCRCLR state; reset enters IDLE directly.
  - Buffer contents after reset are whatever the buffer's initial image holds.
  - 0x0C is treated as printable.

## Structure
- Shared package console_pkg holds:
  - COLS, ROWS, CELLS (= COLS*ROWS), ADDR_W
  - Control codes CHR_BS, CHR_LF, CHR_CR, CHR_FF, CHR_SP
  - State encoding localparams
- One natural sub-module: cell_sweep, a start/length address sequencer driving LINECLR and SCRCLR.
  - Inputs: start address, count.
  - Outputs: addr, active, done.
  - Reuses mod_n_counter for the step count.

## Test plan
- Reset with macro: buf_we high for 6360 consecutive cycles, addr 0..6359, data 0x20; then in_ready = 1 and cursor (0,0).
- Send "AB" back-to-back from (0,0): writes (0,0x41) and (1,0x42) on consecutive cycles; cursor (2,0).
- Send 106 printable bytes from (0,0):
  - The 106th byte writes addr 105.
  - Then 106 writes of 0x20 at addr 106..211, with in_ready low for 107 cycles.
  - Cursor ends at (0,1).
- Cursor at (5,59), send 0x0A: no glyph write; row 0 cleared (addr 0..105); cursor (0,0).
- Cursor at (0,3), send 0x08 then 0x0D: no writes and cursor stays (0,3). From (7,3), 0x08 gives (6,3).
- Assert rst during LINECLR at sweep step 50: buf_we drops immediately, outputs take reset values, and a fresh full sweep starts (macro build).

Source files
------------

// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_pkg
// Description : Shared geometry, control codes and state encoding for the
//               character-cell console controller.
// Revision    : 1.0 - initial release
// ============================================================================
package console_pkg;

    localparam int COLS   = 106;
    localparam int ROWS   = 60;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 13;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [6:0]        col_t;
    typedef logic [5:0]        row_t;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_SP = 8'h20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LINECLR = 2'd1;
    localparam logic [1:0] ST_SCRCLR  = 2'd2;

    localparam col_t  COL_LAST = col_t'(COLS - 1);
    localparam row_t  ROW_LAST = row_t'(ROWS - 1);
    localparam addr_t COLS_A   = addr_t'(COLS);
    localparam addr_t CELLS_A  = addr_t'(CELLS);

    function automatic addr_t cell_addr(input row_t row, input col_t col);
        return addr_t'(row) * COLS_A + addr_t'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_console_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : text_console_ctrl_if
// Description : Byte-stream input and character-buffer write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface text_console_ctrl_if
    import console_pkg::*;
();
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       buf_we;
    addr_t      buf_addr;
    logic [7:0] buf_data;
    col_t       cursor_col;
    row_t       cursor_row;
    logic       busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, buf_we, buf_addr, buf_data, cursor_col, cursor_row, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, buf_we, buf_addr, buf_data, cursor_col, cursor_row, busy
    );
endinterface
`default_nettype wire

// File: rtl/cell_sweep.sv
`default_nettype none
// ============================================================================
// Module      : cell_sweep
// Description : Emits count_i ascending addresses from start_addr_i, one per
//               cycle, after a start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_sweep
    import console_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start_i,
    input  addr_t start_addr_i,
    input  addr_t count_i,
    output addr_t addr_o,
    output logic  active_o,
    output logic  done_o
);
    addr_t base_q;
    addr_t len_q;
    logic  active_q;
    addr_t step_w;
    logic  last_w;

    mod_n_counter #(.WIDTH(ADDR_W)) u_step (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_i),
        .en_i    (active_q),
        .n_i     (len_q),
        .count_o (step_w),
        .last_o  (last_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            base_q   <= start_addr_i;
            len_q    <= count_i;
            active_q <= 1'b1;
        end else if (active_q && last_w) begin
            active_q <= 1'b0;
        end
    end

    assign addr_o   = base_q + step_w;
    assign active_o = active_q;
    assign done_o   = active_q && last_w;
endmodule
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_counter
// Description : Enable-gated counter wrapping at a run-time modulus n_i.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);
    logic [WIDTH-1:0] count_q;

    assign last_o  = (count_q == (n_i - WIDTH'(1)));
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= last_o ? '0 : count_q + WIDTH'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_console_ctrl
// Description : Byte stream to character-buffer writes with cursor tracking
//               and line clears; TEXT_CONSOLE_CLEAR_EN adds full-screen clear.
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_ctrl
    import console_pkg::*;
(
    input  logic               clk_25,
    input  logic               rst,
    text_console_ctrl_if.slave bus
);
`ifdef TEXT_CONSOLE_CLEAR_EN
    localparam logic [1:0] RST_STATE = ST_SCRCLR;
`else
    localparam logic [1:0] RST_STATE = ST_IDLE;
`endif

    logic [1:0] state_q, state_d;
    logic       ready_q, ready_d;
    logic       busy_q;
    logic       we_q, we_d;
    addr_t      addr_q, addr_d;
    logic [7:0] data_q, data_d;
    col_t       col_q, col_d;
    row_t       row_q, row_d;
    logic       fin_q;
`ifdef TEXT_CONSOLE_CLEAR_EN
    logic       pwr_q;
`endif

    logic  accept_w, is_lf_w, is_cr_w, is_bs_w, is_ff_w, is_print_w, row_adv_w;
    logic  sw_start_w, sw_active_w, sw_done_w;
    addr_t sw_base_w, sw_count_w, sw_addr_w;

    always_comb begin
        accept_w   = ready_q && bus.in_valid;
        is_lf_w    = (bus.in_data == CHR_LF);
        is_cr_w    = (bus.in_data == CHR_CR);
        is_bs_w    = (bus.in_data == CHR_BS);
`ifdef TEXT_CONSOLE_CLEAR_EN
        is_ff_w    = (bus.in_data == CHR_FF);
`else
        is_ff_w    = 1'b0;
`endif
        is_print_w = !(is_lf_w || is_cr_w || is_bs_w || is_ff_w);
        row_adv_w  = is_lf_w || (is_print_w && (col_q == COL_LAST));
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            ready_q <= (RST_STATE == ST_IDLE);
            busy_q  <= (RST_STATE != ST_IDLE);
            fin_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= CHR_SP;
            col_q   <= '0;
            row_q   <= '0;
`ifdef TEXT_CONSOLE_CLEAR_EN
            pwr_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= !ready_d;
            fin_q   <= sw_done_w;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            col_q   <= col_d;
            row_q   <= row_d;
`ifdef TEXT_CONSOLE_CLEAR_EN
            pwr_q   <= 1'b0;
`endif
        end
    end

    // fin_q marks the cycle after the sweep's last address, so the final
    // clear write is already on the bus when the state leaves the sweep.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    if (is_ff_w)        state_d = ST_SCRCLR;
                    else if (row_adv_w) state_d = ST_LINECLR;
                end
            end
            ST_LINECLR: if (fin_q) state_d = ST_IDLE;
`ifdef TEXT_CONSOLE_CLEAR_EN
            ST_SCRCLR:  if (fin_q) state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        sw_start_w = 1'b0;
        sw_base_w  = '0;
        sw_count_w = COLS_A;

        if (sw_active_w) begin
            we_d   = 1'b1;
            addr_d = sw_addr_w;
            data_d = CHR_SP;
        end

        if (accept_w) begin
            if (is_print_w) begin
                we_d   = 1'b1;
                addr_d = cell_addr(row_q, col_q);
                data_d = bus.in_data;
            end
            if (is_cr_w || row_adv_w)           col_d = '0;
            else if (is_print_w)                col_d = col_q + 7'd1;
            else if (is_bs_w && col_q != '0)    col_d = col_q - 7'd1;

            if (row_adv_w) begin
                row_d      = (row_q == ROW_LAST) ? '0 : row_q + 6'd1;
                sw_start_w = 1'b1;
                sw_base_w  = cell_addr(row_d, '0);
                sw_count_w = COLS_A;
            end
            if (is_ff_w) begin
                sw_start_w = 1'b1;
                sw_count_w = CELLS_A;
            end
        end

`ifdef TEXT_CONSOLE_CLEAR_EN
        if (pwr_q) begin
            sw_start_w = 1'b1;
            sw_count_w = CELLS_A;
        end
        if (state_q == ST_SCRCLR && fin_q) begin
            col_d = '0;
            row_d = '0;
        end
`endif

        ready_d = (state_d == ST_IDLE);
    end

    cell_sweep u_sweep (
        .clk          (clk_25),
        .rst          (rst),
        .start_i      (sw_start_w),
        .start_addr_i (sw_base_w),
        .count_i      (sw_count_w),
        .addr_o       (sw_addr_w),
        .active_o     (sw_active_w),
        .done_o       (sw_done_w)
    );

    assign bus.in_ready   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.buf_we     = we_q;
    assign bus.buf_addr   = addr_q;
    assign bus.buf_data   = data_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_console_ctrl
// Description : Self-checking bench for text_console_ctrl with a queue-based
//               write/cursor reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_text_console_ctrl;
    import console_pkg::*;

    logic clk_25 = 1'b0;
    logic rst;
    always #5 clk_25 = ~clk_25;

    text_console_ctrl_if bus ();

    text_console_ctrl dut (
        .clk_25 (clk_25),
        .rst    (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted byte expands into the list of per-cycle
    // bus events it must cause, plus the number of cycles input stays blocked.
    typedef struct packed {
        logic       we;
        logic [12:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  m_col = 0, m_row = 0, m_busy = 0;
    bit  m_ff_pend = 0;

    function automatic wr_t mk(input logic we, input int addr, input logic [7:0] d);
        wr_t w;
        w.we   = we;
        w.addr = addr[12:0];
        w.data = d;
        return w;
    endfunction

    task automatic model_accept(input logic [7:0] b);
        bit ff, adv;
        adv = 0;
`ifdef TEXT_CONSOLE_CLEAR_EN
        ff = (b == 8'h0C);
`else
        ff = 0;
`endif
        if (ff) begin
            exp_q.push_back(mk(0, 0, 0));
            for (int i = 0; i < CELLS; i++) exp_q.push_back(mk(1, i, 8'h20));
            m_busy = CELLS + 1;
            m_ff_pend = 1;
        end else if (b == 8'h0A) begin
            exp_q.push_back(mk(0, 0, 0));
            m_col = 0;
            adv = 1;
        end else if (b == 8'h0D) begin
            exp_q.push_back(mk(0, 0, 0));
            m_col = 0;
        end else if (b == 8'h08) begin
            exp_q.push_back(mk(0, 0, 0));
            if (m_col > 0) m_col--;
        end else begin
            exp_q.push_back(mk(1, m_row * COLS + m_col, b));
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                adv = 1;
            end
        end
        if (adv) begin
            m_row = (m_row + 1) % ROWS;
            for (int i = 0; i < COLS; i++) exp_q.push_back(mk(1, m_row * COLS + i, 8'h20));
            m_busy = COLS + 1;
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        wr_t e;
        bit  acc;
        @(negedge clk_25);
        bus.in_valid = v;
        bus.in_data  = d;
        chk("in_ready", bus.in_ready, m_busy == 0);
        chk("busy", bus.busy, m_busy != 0);
        @(posedge clk_25);
        acc = v && (m_busy == 0);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_ff_pend) begin
                m_col = 0;
                m_row = 0;
                m_ff_pend = 0;
            end
        end
        if (acc) model_accept(d);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk(0, 0, 0);
        chk("buf_we", bus.buf_we, e.we);
        if (e.we) begin
            chk("buf_addr", bus.buf_addr, e.addr);
            chk("buf_data", bus.buf_data, e.data);
        end
        chk("cursor_col", bus.cursor_col, m_col);
        chk("cursor_row", bus.cursor_row, m_row);
    endtask

    task automatic drain();
        int g = 0;
        while (m_busy != 0 && g < CELLS + 10) begin
            tick(0, 8'h00);
            g++;
        end
    endtask

`ifdef TEXT_CONSOLE_CLEAR_EN
    task automatic sweep_check();
        int k = 0;
        bit ok = 1;
        while (!bus.buf_we && k < 10) begin
            @(posedge clk_25); #1;
            k++;
        end
        chk("sweep_start", bus.buf_we, 1);
        for (int i = 0; i < CELLS && ok; i++) begin
            if (i > 0) begin
                @(posedge clk_25); #1;
            end
            checks++;
            if (bus.buf_we !== 1'b1 || bus.buf_addr !== 13'(i) || bus.buf_data !== 8'h20) begin
                errors++;
                ok = 0;
                $display("FAIL sweep step %0d: we=%0d addr=%0d data=%0h expected we=1 addr=%0d data=20",
                         i, bus.buf_we, bus.buf_addr, bus.buf_data, i);
            end
        end
        @(posedge clk_25); #1;
        chk("sweep_ready", bus.in_ready, 1);
        chk("sweep_we_off", bus.buf_we, 0);
        chk("sweep_col", bus.cursor_col, 0);
        chk("sweep_row", bus.cursor_row, 0);
    endtask
`endif

    typedef struct {
        logic [7:0] b;
        logic       we;
        logic [7:0] data;
        int         addr;
        int         col;
        int         row;
    } vec_t;

    vec_t vt[8];

    initial begin
        int base, lowcnt, g, r0;
        logic [7:0] rb;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk_25);
        #1;
        chk("rst_we", bus.buf_we, 0);
        chk("rst_addr", bus.buf_addr, 0);
        chk("rst_data", bus.buf_data, 8'h20);
        chk("rst_col", bus.cursor_col, 0);
        chk("rst_row", bus.cursor_row, 0);
`ifdef TEXT_CONSOLE_CLEAR_EN
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 1);
`else
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
`endif
        @(negedge clk_25);
        rst = 1'b0;
`ifdef TEXT_CONSOLE_CLEAR_EN
        sweep_check();
`endif

        // Single-byte vectors applied back to back from (0,0).
        vt[0] = '{8'h41, 1'b1, 8'h41, 0,   1, 0};
        vt[1] = '{8'h42, 1'b1, 8'h42, 1,   2, 0};
        vt[2] = '{8'h08, 1'b0, 8'h00, 0,   1, 0};
        vt[3] = '{8'h0D, 1'b0, 8'h00, 0,   0, 0};
        vt[4] = '{8'h08, 1'b0, 8'h00, 0,   0, 0};
        vt[5] = '{8'h0A, 1'b0, 8'h00, 0,   0, 1};
        vt[6] = '{8'h78, 1'b1, 8'h78, 106, 1, 1};
`ifdef TEXT_CONSOLE_CLEAR_EN
        vt[7] = '{8'h0C, 1'b0, 8'h00, 0,   1, 1};
`else
        vt[7] = '{8'h0C, 1'b1, 8'h0C, 107, 2, 1};
`endif
        for (int i = 0; i < 8; i++) begin
            tick(1, vt[i].b);
            chk("vec_we", bus.buf_we, vt[i].we);
            if (vt[i].we) begin
                chk("vec_addr", bus.buf_addr, vt[i].addr);
                chk("vec_data", bus.buf_data, vt[i].data);
            end
            chk("vec_col", bus.cursor_col, vt[i].col);
            chk("vec_row", bus.cursor_row, vt[i].row);
            drain();
        end
`ifdef TEXT_CONSOLE_CLEAR_EN
        chk("ff_home_col", bus.cursor_col, 0);
        chk("ff_home_row", bus.cursor_row, 0);
`endif

        // A full row of printables: wrap, line clear, input blocked COLS+1 cycles.
        tick(1, 8'h0D);
        r0 = m_row;
        for (int i = 0; i < COLS; i++) tick(1, 8'h41 + 8'(i % 26));
        chk("row_last_addr", bus.buf_addr, r0 * COLS + COLS - 1);
        lowcnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.in_ready) break;
            lowcnt++;
            tick(0, 8'h00);
        end
        chk("ready_low_cycles", lowcnt, COLS + 1);
        chk("wrap_col", bus.cursor_col, 0);
        chk("wrap_row", bus.cursor_row, (r0 + 1) % ROWS);

        // Walk to the bottom row, then LF wraps to row 0 and clears it.
        g = 0;
        while (m_row != ROWS - 1 && g < ROWS + 2) begin
            tick(1, 8'h0A);
            drain();
            g++;
        end
        for (int i = 0; i < 5; i++) tick(1, 8'h61);
        chk("pre_lf_col", bus.cursor_col, 5);
        chk("pre_lf_row", bus.cursor_row, 59);
        tick(1, 8'h0A);
        chk("lf_no_glyph", bus.buf_we, 0);
        chk("lf_wrap_col", bus.cursor_col, 0);
        chk("lf_wrap_row", bus.cursor_row, 0);
        drain();

        // Backspace / carriage return at column 0, then backspace mid-row.
        for (int i = 0; i < 3; i++) begin
            tick(1, 8'h0A);
            drain();
        end
        tick(1, 8'h08);
        chk("bs0_we", bus.buf_we, 0);
        chk("bs0_col", bus.cursor_col, 0);
        chk("bs0_row", bus.cursor_row, 3);
        tick(1, 8'h0D);
        chk("cr0_we", bus.buf_we, 0);
        chk("cr0_col", bus.cursor_col, 0);
        for (int i = 0; i < 7; i++) tick(1, 8'h63);
        tick(1, 8'h08);
        chk("bs7_we", bus.buf_we, 0);
        chk("bs7_col", bus.cursor_col, 6);
        chk("bs7_row", bus.cursor_row, 3);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'h0A;
                1:       rb = 8'h0D;
                2:       rb = 8'h08;
                default: rb = 8'h20 + 8'($urandom_range(0, 94));
            endcase
            tick($urandom_range(0, 3) != 0, rb);
        end
        bus.in_valid = 1'b0;
        drain();

        // Reset in the middle of a line clear.
        tick(1, 8'h0A);
        base = m_row * COLS;
        g = 0;
        while (!(bus.buf_we && bus.buf_addr == 13'(base + 50)) && g < 200) begin
            tick(0, 8'h00);
            g++;
        end
        chk("step50_reached", g < 200, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_we", bus.buf_we, 0);
        chk("midrst_addr", bus.buf_addr, 0);
        chk("midrst_data", bus.buf_data, 8'h20);
        chk("midrst_col", bus.cursor_col, 0);
        chk("midrst_row", bus.cursor_row, 0);
`ifdef TEXT_CONSOLE_CLEAR_EN
        chk("midrst_ready", bus.in_ready, 0);
`else
        chk("midrst_ready", bus.in_ready, 1);
`endif
        exp_q.delete();
        m_busy = 0;
        m_col = 0;
        m_row = 0;
        m_ff_pend = 0;
        bus.in_valid = 1'b0;
        @(negedge clk_25);
        rst = 1'b0;
`ifdef TEXT_CONSOLE_CLEAR_EN
        sweep_check();
`endif
        tick(1, 8'h5A);
        tick(0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
